// File: rtl/segment_demodulator_pkg.sv
// Shared definitions for the segment demodulator: FSM states, decoded symbol
// values and the accumulator width rule.
package segment_demodulator_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DECIDE
   } demod_state_t;

   localparam int BIT_ZERO = 0;
   localparam int BIT_ONE  = 1;

   // Full-precision product plus log2(SEG_LEN) growth bits plus one guard bit
   // so that (-2^(W-1))^2 * SEG_LEN stays positive.
   function automatic int acc_width(input int width, input int seg_len);
      return 2 * width + $clog2(seg_len) + 1;
   endfunction

endpackage

// File: rtl/segment_demodulator_signed_mac.sv
// Signed multiply-accumulate: full-width product sign-extended into the
// accumulator, with synchronous clear and enable.
module signed_mac #(
   parameter int WIDTH = 32,
   parameter int ACC_W = 2 * WIDTH + 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   prod_ext;

   assign prod     = a * b;
   assign prod_ext = {{(ACC_W - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/segment_demodulator.sv
// Correlates one received segment against the reference waveform and decodes
// the symbol from the sign of the correlation sum.
module segment_demodulator
   import segment_demodulator_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SEG_LEN = 8,
   parameter int ACC_W   = acc_width(WIDTH, SEG_LEN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    sample_valid,
   input  logic signed [WIDTH-1:0] rx_sample,
   input  logic signed [WIDTH-1:0] ref_sample,
   output logic        [WIDTH-1:0] output_bit,
   output logic signed [ACC_W-1:0] corr_out,
   output logic                    valid,
   output logic                    busy
);

   localparam int CNT_W = $clog2(SEG_LEN);

   demod_state_t            state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    busy_d;
   logic                    valid_d;
   logic [WIDTH-1:0]        output_bit_d;
   logic signed [ACC_W-1:0] corr_d;
   logic signed [ACC_W-1:0] acc;
   logic                    mac_clear;
   logic                    mac_en;

   assign mac_clear = (state_q == IDLE) && start;
   assign mac_en    = (state_q == ACCUM) && sample_valid;

   signed_mac #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clear (mac_clear),
      .en    (mac_en),
      .a     (rx_sample),
      .b     (ref_sample),
      .acc   (acc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         busy       <= 1'b0;
         valid      <= 1'b0;
         output_bit <= '0;
         corr_out   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy       <= busy_d;
         valid      <= valid_d;
         output_bit <= output_bit_d;
         corr_out   <= corr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      busy_d       = busy;
      valid_d      = 1'b0;
      output_bit_d = output_bit;
      corr_d       = corr_out;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            // The counter stops at SEG_LEN-1; the accumulator takes the last
            // sample on the same edge that moves us to DECIDE.
            if (sample_valid) begin
               if (cnt_q == CNT_W'(SEG_LEN - 1)) begin
                  state_d = DECIDE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DECIDE: begin
            corr_d       = acc;
            output_bit_d = acc[ACC_W-1] ? WIDTH'(BIT_ONE) : WIDTH'(BIT_ZERO);
            valid_d      = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_segment_demodulator.sv
// Bench for segment_demodulator: segment-level reference model checked every
// cycle, plus directed segments with literal expected results.
module tb_segment_demodulator;

   localparam int WIDTH   = 32;
   localparam int SEG_LEN = 8;
   localparam int ACC_W   = 2 * WIDTH + $clog2(SEG_LEN) + 1;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start;
   logic                    sample_valid;
   logic signed [WIDTH-1:0] rx_sample;
   logic signed [WIDTH-1:0] ref_sample;
   logic        [WIDTH-1:0] output_bit;
   logic signed [ACC_W-1:0] corr_out;
   logic                    valid;
   logic                    busy;

   int vectors     = 0;
   int miscompares = 0;

   segment_demodulator #(
      .WIDTH   (WIDTH),
      .SEG_LEN (SEG_LEN),
      .ACC_W   (ACC_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .sample_valid (sample_valid),
      .rx_sample    (rx_sample),
      .ref_sample   (ref_sample),
      .output_bit   (output_bit),
      .corr_out     (corr_out),
      .valid        (valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [127:0] act,
                        input logic signed [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Segment-level model: gathers products of accepted samples, decides one
   // cycle after the segment completes. Compared on every falling edge, then
   // advanced with the inputs the next rising edge will sample.
   initial begin
      bit                      m_active = 0;
      bit                      m_decide = 0;
      int                      m_n = 0;
      logic signed [ACC_W-1:0] m_sum = '0;
      logic signed [2*WIDTH-1:0] p;
      logic                    e_valid = 0;
      logic                    e_busy = 0;
      logic [WIDTH-1:0]        e_bit = '0;
      logic signed [ACC_W-1:0] e_corr = '0;
      forever begin
         @(negedge clk);
         check("valid", valid, e_valid);
         check("busy", busy, e_busy);
         check("output_bit", output_bit, e_bit);
         check("corr_out", corr_out, e_corr);
         if (reset) begin
            m_active = 0; m_decide = 0; m_n = 0; m_sum = '0;
            e_valid = 0; e_busy = 0; e_bit = '0; e_corr = '0;
         end else begin
            e_valid = 0;
            if (m_decide) begin
               e_corr   = m_sum;
               e_bit    = (m_sum < 0) ? 1 : 0;
               e_valid  = 1;
               e_busy   = 0;
               m_decide = 0;
            end else if (!m_active) begin
               if (start) begin
                  m_active = 1; m_n = 0; m_sum = '0; e_busy = 1;
               end
            end else if (sample_valid) begin
               p     = rx_sample * ref_sample;
               m_sum = m_sum + p;
               m_n++;
               if (m_n == SEG_LEN) begin
                  m_active = 0;
                  m_decide = 1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_seg(input logic signed [WIDTH-1:0] rxv[SEG_LEN],
                           input logic signed [WIDTH-1:0] refv[SEG_LEN],
                           input int gap_after, input int gap_len,
                           input bit mid_start, output int ticks);
      ticks = 0;
      start = 1'b1;
      tick(); ticks++;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      for (int i = 0; i < SEG_LEN; i++) begin
         sample_valid = 1'b1;
         rx_sample    = rxv[i];
         ref_sample   = refv[i];
         start        = (mid_start && i == 2);
         tick(); ticks++;
         start        = 1'b0;
         sample_valid = 1'b0;
         if (i == gap_after) begin
            repeat (gap_len) begin
               rx_sample = 32'sd12345;
               tick(); ticks++;
            end
         end
      end
   endtask

   task automatic wait_valid(output int lat);
      bit found = 0;
      lat = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
         tick();
         if (valid === 1'b1) begin
            found = 1;
            lat   = i;
         end
      end
      if (!found) check("valid_timeout", 0, 1);
   endtask

   task automatic count_valids(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (valid === 1'b1) cnt++;
      end
   endtask

   initial begin
      logic signed [WIDTH-1:0] ra[SEG_LEN];
      logic signed [WIDTH-1:0] fa[SEG_LEN];
      logic signed [127:0]     big;
      int                      ticks, lat, nv;
      int                      zs[SEG_LEN] = '{5, -9, 300, 7, 5, -9, 300, 7};

      reset = 1'b1; start = 1'b0; sample_valid = 1'b0;
      rx_sample = '0; ref_sample = '0;
      repeat (3) tick();
      reset = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_valid", valid, 0);
      check("reset_bit", output_bit, 0);
      check("reset_corr", corr_out, 0);

      // Matched segment
      for (int i = 0; i < SEG_LEN; i++) begin ra[i] = 1000; fa[i] = 1000; end
      send_seg(ra, fa, -1, 0, 0, ticks);
      wait_valid(lat);
      check("lat_matched", lat, 1);
      check("total_matched", ticks + lat, 10);
      check("bit_matched", output_bit, 0);
      check("corr_matched", corr_out, 8000000);
      check("busy_at_valid", busy, 0);

      // Negated segment, started in the valid cycle
      for (int i = 0; i < SEG_LEN; i++) begin ra[i] = -1000; fa[i] = 1000; end
      send_seg(ra, fa, -1, 0, 0, ticks);
      wait_valid(lat);
      check("lat_negated", lat, 1);
      check("bit_negated", output_bit, 1);
      check("corr_negated", corr_out, -8000000);

      // Gap of three cycles after the fourth sample
      for (int i = 0; i < SEG_LEN; i++) begin ra[i] = 1000; fa[i] = 1000; end
      send_seg(ra, fa, 3, 3, 0, ticks);
      wait_valid(lat);
      check("total_gap", ticks + lat, 13);
      check("bit_gap", output_bit, 0);
      check("corr_gap", corr_out, 8000000);

      // Products cancel exactly: zero decodes as 0
      for (int i = 0; i < SEG_LEN; i++) begin
         fa[i] = zs[i];
         ra[i] = (i < 4) ? zs[i] : -zs[i];
      end
      send_seg(ra, fa, -1, 0, 0, ticks);
      wait_valid(lat);
      check("bit_zero", output_bit, 0);
      check("corr_zero", corr_out, 0);

      // Most negative samples: sum of 8 * 2^62
      for (int i = 0; i < SEG_LEN; i++) begin ra[i] = 32'sh8000_0000; fa[i] = 32'sh8000_0000; end
      send_seg(ra, fa, -1, 0, 0, ticks);
      wait_valid(lat);
      big = 1;
      big = big << 65;
      check("bit_extreme", output_bit, 0);
      check("corr_extreme", corr_out, big);

      // Start during a segment must not restart it
      for (int i = 0; i < SEG_LEN; i++) begin ra[i] = 3; fa[i] = 3; end
      send_seg(ra, fa, -1, 0, 1, ticks);
      wait_valid(lat);
      check("lat_midstart", lat, 1);
      check("corr_midstart", corr_out, 72);
      count_valids(5, nv);
      check("single_valid", nv, 0);

      // Reset after five samples discards the segment
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sample_valid = 1'b1; rx_sample = 777; ref_sample = 777;
         tick();
      end
      sample_valid = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_bit", output_bit, 0);
      check("rst_mid_corr", corr_out, 0);
      count_valids(12, nv);
      check("rst_mid_no_valid", nv, 0);
      for (int i = 0; i < SEG_LEN; i++) begin fa[i] = (i + 1) * 1000; ra[i] = -fa[i]; end
      send_seg(ra, fa, -1, 0, 0, ticks);
      wait_valid(lat);
      check("bit_after_rst", output_bit, 1);
      check("corr_after_rst", corr_out, -204000000);

      // Random traffic, checked by the model every cycle
      for (int c = 0; c < 1500; c++) begin
         reset        = ($urandom_range(0, 199) == 0);
         start        = ($urandom_range(0, 3) == 0);
         sample_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: begin rx_sample = 32'sh8000_0000; ref_sample = 32'sh8000_0000; end
            1: begin rx_sample = 32'sh7FFF_FFFF; ref_sample = 32'sh8000_0000; end
            default: begin rx_sample = $urandom; ref_sample = $urandom; end
         endcase
         tick();
      end
      reset = 1'b0; start = 1'b0; sample_valid = 1'b0;
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
